// File: rtl/calc_tx_pkg.sv
// Shared types, ASCII constants and helpers for the calculator result UART transmitter.
// CALC_TX_HEX_EN adds the NEXT state used to chain the three hex frames.
package calc_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef CALC_TX_HEX_EN
    , NEXT
`endif
  } state_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam int         FRAME_BITS = 10;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/calc_baud_gen.sv
// Bit-period down-counter: loads CLKS_PER_BIT-1, pulses bit_tick on reaching 0.
// While restart is high the counter is held at its load value and no tick is produced.
module calc_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (restart || cnt == '0)   cnt <= LOAD;
    else                             cnt <= cnt - CW'(1);
  end

  assign bit_tick = !restart && (cnt == '0);

endmodule

// File: rtl/calc_result_tx.sv
// Sends each accepted calculator result over a UART line (8N1, LSB first).
// Define CALC_TX_HEX_EN to send two uppercase hex digits plus CR instead of the raw byte.
//
// state | meaning
// IDLE  | line high, accepting a result when ena is high
// START | start bit (0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1)
// NEXT  | one-cycle gap that loads the next hex character (hex build only)
module calc_result_tx
  import calc_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic              tx_q, tx_nxt;
  logic              armed;
  logic              restart, bit_tick, xfer;
`ifdef CALC_TX_HEX_EN
  logic [7:0]        res_byte, byte_nxt;
  logic [1:0]        char_idx, char_nxt;
`endif

  calc_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  // armed keeps res_ready low until the first edge after reset release
  assign res_ready = armed && ena && (state == IDLE);
  assign xfer      = res_valid && res_ready;
  assign busy      = (state != IDLE);
  assign tx        = tx_q;
`ifdef CALC_TX_HEX_EN
  assign restart   = (state == IDLE) || (state == NEXT);
`else
  assign restart   = (state == IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      armed    <= 1'b0;
`ifdef CALC_TX_HEX_EN
      res_byte <= '0;
      char_idx <= '0;
`endif
    end else begin
      state    <= state_nxt;
      sh       <= sh_nxt;
      bit_idx  <= bit_nxt;
      tx_q     <= tx_nxt;
      armed    <= 1'b1;
`ifdef CALC_TX_HEX_EN
      res_byte <= byte_nxt;
      char_idx <= char_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    bit_nxt   = bit_idx;
    tx_nxt    = tx_q;
`ifdef CALC_TX_HEX_EN
    byte_nxt  = res_byte;
    char_nxt  = char_idx;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          bit_nxt   = '0;
`ifdef CALC_TX_HEX_EN
          byte_nxt  = res_data;
          char_nxt  = '0;
          sh_nxt    = nib_to_ascii(res_data[7:4]);
`else
          sh_nxt    = res_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt = DATA;
          tx_nxt    = sh[0];
          sh_nxt    = sh >> 1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_BIT) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt    = sh[0];
            sh_nxt    = sh >> 1;
            bit_nxt   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
`ifdef CALC_TX_HEX_EN
          state_nxt = (char_idx == 2'd2) ? IDLE : NEXT;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef CALC_TX_HEX_EN
      NEXT: begin
        state_nxt = START;
        tx_nxt    = 1'b0;
        bit_nxt   = '0;
        char_nxt  = char_idx + 2'd1;
        sh_nxt    = (char_idx == 2'd0) ? nib_to_ascii(res_byte[3:0]) : ASCII_CR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/calc_result_tx.md
CALC_RESULT_TX -- requirements
Module: calc_result_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (legal range 2..1023).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the calculator result width (fixed to 8 in this revision).
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ena  input  1  design-selected enable; new results are accepted only while it is high.
REQ-006 res_valid  input  1  calculator result available.
REQ-007 res_data  input  8  calculator result byte.
REQ-008 res_ready  output  1  block accepts res_data this cycle.
REQ-009 tx  output  1  UART serial line; idles high.
REQ-010 busy  output  1  high while any frame of the current result is in flight.

Function
REQ-011 A transfer SHALL occur on a rising clk edge where res_valid and res_ready are both 1; res_data SHALL be latched on that edge.
REQ-012 res_ready SHALL be 1 only in state IDLE with ena=1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, plus NEXT when CALC_TX_HEX_EN is defined.
REQ-014 IDLE->START on transfer; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->IDLE after CLKS_PER_BIT cycles (or STOP->NEXT while characters remain).
REQ-015 tx SHALL show the start bit (0) from the cycle after the transfer, then data LSB first, then the stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-016 One frame SHALL last exactly 10*CLKS_PER_BIT cycles, and back-to-back results SHALL be separated by exactly one IDLE cycle.
REQ-017 The bit-timing counter SHALL load CLKS_PER_BIT-1 at each bit start, count down to 0, and never wrap without a bit advance.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Deasserting ena mid-frame SHALL NOT truncate the frame; it SHALL only block the next acceptance.
REQ-020 res_valid or res_data changes while busy SHALL be ignored.

Reset
REQ-021 rst=1 SHALL immediately, independent of clk, force state IDLE, tx=1, busy=0, res_ready=0, and clear the counters and the shift register.
REQ-022 A reset asserted mid-frame SHALL abort the frame with no partial retransmission after release.
REQ-023 After rst deasserts, res_ready SHALL rise on the first clk edge where ena=1.

Configuration
REQ-024 Macro CALC_TX_HEX_EN SHALL select the output format.
REQ-025 With CALC_TX_HEX_EN defined, each result SHALL be sent as three frames: the ASCII uppercase hex of the high nibble, the ASCII hex of the low nibble, then 0x0D.
REQ-026 In hex mode, NEXT SHALL last one cycle between frames and busy SHALL stay high across all three frames.
REQ-027 With CALC_TX_HEX_EN undefined, each result SHALL be sent as one raw frame, and NEXT and the hex logic SHALL be absent.

Structure
REQ-028 Package calc_tx_pkg SHALL hold the state enum, the ASCII constants (0x30, 0x41, 0x0D), the frame bit count (10), and the nibble-to-ASCII function.
REQ-029 Sub-module calc_baud_gen SHALL provide the CLKS_PER_BIT countdown and a one-cycle bit_tick pulse, with inputs clk, rst, and restart.

Verification (CLKS_PER_BIT=4)
REQ-030 Reset held, then released with ena=1 -> tx=1, busy=0, and res_ready=1 on the first edge.
REQ-031 Raw mode, res_data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, 40 cycles total, and busy falls on cycle 41.
REQ-032 Raw mode, res_valid held with 0x01 then 0xFF -> two frames exactly one IDLE cycle apart, and res_ready pulses once per frame.
REQ-033 Hex mode, res_data=0x3C -> frames 0x33, 0x43, 0x0D, with busy continuously high for 3*40+2 cycles.
REQ-034 rst pulsed at cycle 15 of a frame -> tx=1 in the same cycle and no further low bits after release.
REQ-035 ena dropped at cycle 5 of a frame -> the frame completes intact and res_ready stays 0 until ena=1.
